// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory bus bridge.
// Size encodings follow funct3[1:0]: byte, half, word, double.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP,
    ST_DONE
  } dmem_state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  function automatic logic [7:0] size_to_mask(input logic [1:0] size);
    logic [7:0] mask;
    case (size)
      SZ_B:    mask = 8'h01;
      SZ_H:    mask = 8'h03;
      SZ_W:    mask = 8'h0F;
      default: mask = 8'hFF;
    endcase
    return mask;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] offset, input logic [1:0] size);
    logic mis;
    case (size)
      SZ_B:    mis = 1'b0;
      SZ_H:    mis = offset[0];
      SZ_W:    mis = |offset[1:0];
      default: mis = |offset;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Places right-aligned store data and its byte strobes onto the 8-byte bus lanes.
// Purely combinational; no latency, no flow control.
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter int N = 64
) (
  input  logic [2:0]   offset,
  input  logic [1:0]   size,
  input  logic [N-1:0] data,
  output logic [N-1:0] wdata,
  output logic [7:0]   wstrb
);

  assign wdata = data << {offset, 3'b000};
  assign wstrb = size_to_mask(size) << offset;

endmodule

// File: rtl/dmem_bridge.sv
// Bridges the datapath's combinational data-memory port onto a valid/ready bus.
// Min 3 stall cycles + 1 completion cycle; stalls the core for any bus wait state.
// Optional DMEM_TIMEOUT_EN bounds the REQ/RESP wait to TIMEOUT_CYCLES cycles.
module dmem_bridge
  import dmem_pkg::*;
#(
  parameter int N              = 64,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] DM_addr,
  input  logic [N-1:0] DM_writeData,
  input  logic         DM_writeEnable,
  input  logic         DM_readEnable,
  input  logic [2:0]   memWidth,
  output logic [N-1:0] DM_readData,
  output logic         dm_stall,
  output logic         dm_accessFault,
  output logic         bus_req_valid,
  input  logic         bus_req_ready,
  output logic         bus_req_we,
  output logic [N-1:0] bus_addr,
  output logic [N-1:0] bus_wdata,
  output logic [7:0]   bus_wstrb,
  input  logic         bus_resp_valid,
  input  logic [N-1:0] bus_resp_rdata,
  input  logic         bus_resp_err
);

  dmem_state_t  state;
  logic         req_any;
  logic         misaligned;
  logic         tmo_hit;
  logic [N-1:0] al_wdata;
  logic [7:0]   al_wstrb;
  logic         unused_width;

  assign unused_width = memWidth[2];
  assign req_any      = DM_writeEnable | DM_readEnable;
  assign misaligned   = is_misaligned(DM_addr[2:0], memWidth[1:0]);

  dmem_lane_align #(.N(N)) u_align (
    .offset (DM_addr[2:0]),
    .size   (memWidth[1:0]),
    .data   (DM_writeData),
    .wdata  (al_wdata),
    .wstrb  (al_wstrb)
  );

  // The core must freeze in the very cycle it presents the access.
  assign dm_stall = ~reset & (((state == ST_IDLE) & req_any) |
                              (state == ST_REQ) | (state == ST_RESP));

`ifdef DMEM_TIMEOUT_EN
  logic [7:0] tmo_cnt;

  always_ff @(posedge clk) begin
    if (reset || state == ST_IDLE || state == ST_DONE) tmo_cnt <= '0;
    else                                              tmo_cnt <= tmo_cnt + 8'd1;
  end

  assign tmo_hit = (tmo_cnt == 8'(TIMEOUT_CYCLES - 1));
`else
  localparam int unused_tmo = TIMEOUT_CYCLES;
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      DM_readData    <= '0;
      dm_accessFault <= 1'b0;
      bus_req_valid  <= 1'b0;
      bus_req_we     <= 1'b0;
      bus_addr       <= '0;
      bus_wdata      <= '0;
      bus_wstrb      <= 8'h00;
    end else begin
      dm_accessFault <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_any) begin
            if (misaligned) begin
              state          <= ST_DONE;
              dm_accessFault <= 1'b1;
              if (!DM_writeEnable) DM_readData <= '0;
            end else begin
              state         <= ST_REQ;
              bus_req_valid <= 1'b1;
              bus_req_we    <= DM_writeEnable;
              bus_addr      <= {DM_addr[N-1:3], 3'b000};
              bus_wdata     <= al_wdata;
              bus_wstrb     <= DM_writeEnable ? al_wstrb : 8'h00;
            end
          end
        end
        ST_REQ: begin
          if (bus_req_ready) begin
            bus_req_valid <= 1'b0;
            state         <= ST_RESP;
          end else if (tmo_hit) begin
            bus_req_valid  <= 1'b0;
            state          <= ST_DONE;
            dm_accessFault <= 1'b1;
            DM_readData    <= '0;
          end
        end
        ST_RESP: begin
          if (bus_resp_valid) begin
            state          <= ST_DONE;
            dm_accessFault <= bus_resp_err;
            if (!bus_req_we) DM_readData <= bus_resp_err ? '0 : bus_resp_rdata;
          end else if (tmo_hit) begin
            state          <= ST_DONE;
            dm_accessFault <= 1'b1;
            DM_readData    <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/dmem_bridge.md
Name: dmem_bridge

Overview:
- Data-memory bus bridge directly downstream of the single-cycle datapath's data-memory port.
- Converts the combinational DM request (DM_addr, DM_writeData, DM_writeEnable, DM_readEnable) into a valid/ready bus transaction with arbitrary wait states.
- Holds the core via dm_stall until the access completes.
- Returns raw 64-bit aligned read data to the datapath; byte/half/word extraction stays in the datapath's read mask.

Parameters:
- N, 64, data and address width; must be 64 (8 byte lanes).
- TIMEOUT_CYCLES, 255, response wait limit; used only with DMEM_TIMEOUT_EN.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- DM_addr  in  N  byte address from ALU
- DM_writeData  in  N  store data, right-aligned
- DM_writeEnable  in  1  store request
- DM_readEnable  in  1  load request
- memWidth  in  3  funct3 width; [1:0]: 0=byte, 1=half, 2=word, 3=double
- DM_readData  out  N  captured 8-byte-aligned read data
- dm_stall  out  1  freeze PC/regfile write while high
- dm_accessFault  out  1  one-cycle pulse: bus error, misalignment or timeout
- bus_req_valid  out  1  request valid
- bus_req_ready  in  1  slave accepts request
- bus_req_we  out  1  1=write
- bus_addr  out  N  DM_addr with [2:0] forced to 0
- bus_wdata  out  N  DM_writeData shifted left by 8*DM_addr[2:0]
- bus_wstrb  out  8  byte strobes, size mask shifted by DM_addr[2:0]; 0 for reads
- bus_resp_valid  in  1  response valid (one cycle)
- bus_resp_rdata  in  N  read data
- bus_resp_err  in  1  slave error, qualified by bus_resp_valid

Behaviour:
- Reset values:
  - State IDLE.
  - All outputs 0, including DM_readData, dm_stall and bus_req_valid.
  - Reset mid-transaction abandons the request; the bus slave shares the same reset.
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE:
  - If DM_writeEnable or DM_readEnable is high, dm_stall=1 combinationally in that same cycle.
  - Latch addr, wdata, strobes, we; go to REQ.
  - Write has priority when both enables are high.
- Misaligned access (addr not a multiple of size): no bus request; go straight to DONE with fault.
- REQ:
  - bus_req_valid=1 with stable latched fields until bus_req_ready is sampled high; then go to RESP.
  - bus_req_valid and bus_req_ready may both be high in the first REQ cycle (zero-wait accept).
- RESP: wait for bus_resp_valid; capture rdata (reads only) and err; go to DONE.
- DONE:
  - dm_stall=0; DM_readData holds captured data; dm_accessFault=err.
  - Enables are ignored this cycle (same instruction still presented); next state is IDLE.
- Minimum access: 3 stall cycles (IDLE, REQ, RESP), plus 1 completion cycle.
- Error read: DM_readData=0.
- Writes: DM_readData keeps its previous value.
- DM_readData is stable from DONE until the next read's DONE.
- Never more than one outstanding transaction.

Optional Feature:
- Macro: DMEM_TIMEOUT_EN.
- Defined:
  - 8-bit counter (width covers TIMEOUT_CYCLES) is cleared on entering REQ and increments each REQ/RESP cycle.
  - Reaching TIMEOUT_CYCLES forces DONE with dm_accessFault=1 and DM_readData=0.
  - A late bus_resp_valid arriving in IDLE is ignored.
- Undefined: no counter; waits indefinitely.

Decomposition:
- Package dmem_pkg:
  - dmem_state_t enum.
  - Size encodings SZ_B/SZ_H/SZ_W/SZ_D.
  - Function size_to_mask (size -> 8-bit base strobe).
  - Function is_misaligned.
- One combinational sub-module dmem_lane_align: offset+size+data -> shifted wdata and wstrb.

Test Plan:
- SD at addr 0x1000 with data 0xDEADBEEF_CAFEF00D, ready on first REQ cycle, response 2 cycles later:
  - bus_wstrb=0xFF, bus_addr=0x1000.
  - dm_stall high for 4 cycles, low in DONE.
- SB at addr 0x1005 with data 0xAB:
  - bus_addr=0x1000, bus_wstrb=0x20, bus_wdata[47:40]=0xAB.
- LW at 0x2004 with rdata 0x11223344_55667788 and ready delayed 3 cycles:
  - bus_req_valid held 4 cycles with stable fields.
  - DM_readData=0x11223344_55667788 in DONE.
- LH at 0x2003 (misaligned):
  - no bus_req_valid.
  - dm_accessFault pulse 1 cycle after request.
- Read with bus_resp_err=1:
  - DM_readData=0, dm_accessFault=1 for exactly one cycle.
- reset asserted during RESP: next cycle state IDLE, all outputs 0.
- With DMEM_TIMEOUT_EN and no response: fault after TIMEOUT_CYCLES.
